// File: rtl/regfile_mp_if.sv
// Write-back / operand-read bundle of the multi-port register file plus its clear handshake.
// Master side is the controller/ALU muxes, slave side is the register file.
interface regfile_mp_if #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int RD_PORTS = 2
);
    logic                       writeEn;
    logic [ADDR_W-1:0]          wrAddr;
    logic [DATA_W-1:0]          wrData;
    logic [RD_PORTS*ADDR_W-1:0] rdAddr;
    logic [RD_PORTS*DATA_W-1:0] rdData;
    logic                       clearReq;
    logic                       busy;
    logic                       clearDone;
    logic                       wrDropped;

    modport master (
        output writeEn, wrAddr, wrData, rdAddr, clearReq,
        input  rdData, busy, clearDone, wrDropped
    );

    modport slave (
        input  writeEn, wrAddr, wrData, rdAddr, clearReq,
        output rdData, busy, clearDone, wrDropped
    );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with async array reset, optional bypass/zero reg, clear sweep.
// Latency: reads combinational (0 cycles); writes commit on posedge; clear sweep takes exactly DEPTH cycles.
// Backpressure: busy high during the sweep; writes arriving then are dropped and flagged by wrDropped next cycle.
module regfile_mp #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 4,
    parameter int RD_PORTS  = 2,
    parameter bit BYPASS    = 1'b1,
    parameter bit ZERO_REG0 = 1'b0
) (
    input  logic          clk,
    input  logic          resetN,
    regfile_mp_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic [ADDR_W-1:0]          ptr;
    logic [ADDR_W-1:0]          ptr_nxt;
    logic [DATA_W-1:0]          mem [DEPTH];
    logic                       busy;
    logic                       sweep_last;
    logic                       wr_commit;
    logic                       wr_drop;
    logic                       wr_dropped_q;
    logic [RD_PORTS*DATA_W-1:0] rd_all;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // clearReq is only looked at in IDLE, so requests during a sweep are never queued.
    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        sweep_last = 1'b0;
        case (state)
            IDLE: begin
                if (bus.clearReq) begin
                    state_nxt = CLEAR;
                    ptr_nxt   = '0;
                end
            end
            CLEAR: begin
                ptr_nxt = ptr + 1'b1;
                if (&ptr) begin
                    sweep_last = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state == CLEAR);
    assign wr_drop   = bus.writeEn && busy;
    assign wr_commit = bus.writeEn && !busy && !(ZERO_REG0 && (bus.wrAddr == '0));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_dropped_q <= 1'b0;
        end else begin
            wr_dropped_q <= wr_drop;
            if (busy) begin
                mem[ptr] <= '0;
            end else if (wr_commit) begin
                mem[bus.wrAddr] <= bus.wrData;
            end
        end
    end

    // Zero register and reset override the bypass; bypass is suppressed while the sweep owns the array.
    always_comb begin : p_read
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;
        rd_all = '0;
        for (int p = 0; p < RD_PORTS; p++) begin
            ra = bus.rdAddr[p*ADDR_W +: ADDR_W];
            rd = mem[ra];
            if (BYPASS && bus.writeEn && !busy && (ra == bus.wrAddr)) begin
                rd = bus.wrData;
            end
            if ((ZERO_REG0 && (ra == '0)) || !resetN) begin
                rd = '0;
            end
            rd_all[p*DATA_W +: DATA_W] = rd;
        end
    end

    assign bus.rdData    = rd_all;
    assign bus.busy      = busy;
    assign bus.clearDone = sweep_last;
    assign bus.wrDropped = wr_dropped_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: three configurations (bypass, zero-reg without bypass, zero-reg with bypass and 3 ports).
module tb_regfile_mp;
    logic clk = 1'b0;
    logic resetN;
    int   errors = 0;
    int   checks = 0;

    logic [15:0] exp_q [$];
    logic        drop_q [$];
    logic [15:0] mdl_a [16];
    logic [15:0] mdl_b [16];
    logic [15:0] mdl_c [16];

    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(16), .ADDR_W(4), .RD_PORTS(2)) ifa ();
    regfile_mp_if #(.DATA_W(16), .ADDR_W(4), .RD_PORTS(2)) ifb ();
    regfile_mp_if #(.DATA_W(16), .ADDR_W(4), .RD_PORTS(3)) ifc ();

    regfile_mp #(.DATA_W(16), .ADDR_W(4), .RD_PORTS(2), .BYPASS(1'b1), .ZERO_REG0(1'b0))
        dut_a (.clk(clk), .resetN(resetN), .bus(ifa));
    regfile_mp #(.DATA_W(16), .ADDR_W(4), .RD_PORTS(2), .BYPASS(1'b0), .ZERO_REG0(1'b1))
        dut_b (.clk(clk), .resetN(resetN), .bus(ifb));
    regfile_mp #(.DATA_W(16), .ADDR_W(4), .RD_PORTS(3), .BYPASS(1'b1), .ZERO_REG0(1'b1))
        dut_c (.clk(clk), .resetN(resetN), .bus(ifc));

    task automatic drive_wr(input int which, input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        case (which)
            0: begin ifa.writeEn = 1'b1; ifa.wrAddr = a; ifa.wrData = d; end
            1: begin ifb.writeEn = 1'b1; ifb.wrAddr = a; ifb.wrData = d; end
            default: begin ifc.writeEn = 1'b1; ifc.wrAddr = a; ifc.wrData = d; end
        endcase
        @(negedge clk);
        ifa.writeEn = 1'b0;
        ifb.writeEn = 1'b0;
        ifc.writeEn = 1'b0;
        case (which)
            0: mdl_a[a] = d;
            1: if (a != 4'd0) mdl_b[a] = d;
            default: if (a != 4'd0) mdl_c[a] = d;
        endcase
    endtask

    task automatic test_reset();
        logic [15:0] got, exp;
        #2;
        ifa.writeEn = 1'b1; ifa.wrAddr = 4'd1; ifa.wrData = 16'hFFFF; ifa.rdAddr = {4'd1, 4'd1};
        exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
        #1;
        for (int p = 0; p < 2; p++) begin
            got = ifa.rdData[p*16 +: 16]; exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL reset_rd p%0d: got %h expected %h", p, got, exp); end
        end
        checks++;
        if ({ifa.busy, ifa.clearDone, ifa.wrDropped, ifb.busy, ifb.clearDone, ifb.wrDropped,
             ifc.busy, ifc.clearDone, ifc.wrDropped} !== 9'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got a=%b%b%b b=%b%b%b c=%b%b%b expected all 0",
                     ifa.busy, ifa.clearDone, ifa.wrDropped, ifb.busy, ifb.clearDone, ifb.wrDropped,
                     ifc.busy, ifc.clearDone, ifc.wrDropped);
        end
        @(negedge clk);
        ifa.writeEn = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        ifa.rdAddr = {4'd0, 4'd1};
        exp_q.push_back(mdl_a[1]); exp_q.push_back(mdl_a[0]);
        #1;
        for (int p = 0; p < 2; p++) begin
            got = ifa.rdData[p*16 +: 16]; exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL post_reset_rd p%0d: got %h expected %h", p, got, exp); end
        end
    endtask

    task automatic test_basic();
        logic [15:0] got, exp;
        drive_wr(0, 4'd0, 16'h0001);
        drive_wr(0, 4'd1, 16'h0007);
        ifa.rdAddr = {4'd1, 4'd0};
        exp_q.push_back(16'h0001); exp_q.push_back(16'h0007);
        #1;
        for (int p = 0; p < 2; p++) begin
            got = ifa.rdData[p*16 +: 16]; exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL basic_rd p%0d: got %h expected %h", p, got, exp); end
        end
        drive_wr(0, 4'd0, 16'h0005);
        exp_q.push_back(16'h0005); exp_q.push_back(16'h0007);
        #1;
        for (int p = 0; p < 2; p++) begin
            got = ifa.rdData[p*16 +: 16]; exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL basic_rewrite p%0d: got %h expected %h", p, got, exp); end
        end
        drive_wr(2, 4'd4, 16'h0042);
        ifc.rdAddr = {4'd4, 4'd4, 4'd4};
        for (int p = 0; p < 3; p++) exp_q.push_back(16'h0042);
        #1;
        for (int p = 0; p < 3; p++) begin
            got = ifc.rdData[p*16 +: 16]; exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL same_addr_rd p%0d: got %h expected %h", p, got, exp); end
        end
    endtask

    task automatic test_bypass();
        logic [15:0] got, exp;
        @(negedge clk);
        ifa.writeEn = 1'b1; ifa.wrAddr = 4'd3; ifa.wrData = 16'hBEEF; ifa.rdAddr = {4'd1, 4'd3};
        ifb.writeEn = 1'b1; ifb.wrAddr = 4'd3; ifb.wrData = 16'hBEEF; ifb.rdAddr = {4'd1, 4'd3};
        exp_q.push_back(16'hBEEF); exp_q.push_back(16'h0007);
        exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
        #1;
        for (int p = 0; p < 2; p++) begin
            got = ifa.rdData[p*16 +: 16]; exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL bypass_on p%0d: got %h expected %h", p, got, exp); end
        end
        for (int p = 0; p < 2; p++) begin
            got = ifb.rdData[p*16 +: 16]; exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL bypass_off p%0d: got %h expected %h", p, got, exp); end
        end
        @(negedge clk);
        ifa.writeEn = 1'b0; ifb.writeEn = 1'b0;
        mdl_a[3] = 16'hBEEF; mdl_b[3] = 16'hBEEF;
        exp_q.push_back(16'hBEEF); exp_q.push_back(16'hBEEF);
        #1;
        got = ifa.rdData[15:0]; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL bypass_after_a: got %h expected %h", got, exp); end
        got = ifb.rdData[15:0]; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL bypass_after_b: got %h expected %h", got, exp); end
    endtask

    task automatic test_clear();
        logic [15:0] got, exp;
        int k, ndone, done_at;
        for (int i = 0; i < 16; i++) drive_wr(0, 4'(i), 16'h1000 + 16'(i));
        ifa.rdAddr = {4'd15, 4'd0};
        ifa.clearReq = 1'b1;
        @(negedge clk);
        ifa.clearReq = 1'b0;
        k = 0; ndone = 0; done_at = -1;
        while (ifa.busy === 1'b1 && k < 40) begin
            k++;
            exp_q.push_back((k - 1 > 0)  ? 16'h0000 : mdl_a[0]);
            exp_q.push_back((k - 1 > 15) ? 16'h0000 : mdl_a[15]);
            #1;
            for (int p = 0; p < 2; p++) begin
                got = ifa.rdData[p*16 +: 16]; exp = exp_q.pop_front(); checks++;
                if (got !== exp) begin errors++; $display("FAIL clear_mid k%0d p%0d: got %h expected %h", k, p, got, exp); end
            end
            if (ifa.clearDone === 1'b1) begin ndone++; done_at = k; end
            @(negedge clk);
        end
        checks++;
        if (k !== 16) begin errors++; $display("FAIL clear_busy_len: got %0d expected 16", k); end
        checks++;
        if (ndone !== 1 || done_at !== 16) begin
            errors++; $display("FAIL clear_done: got %0d pulses at cycle %0d expected 1 at 16", ndone, done_at);
        end
        for (int r = 0; r < 16; r++) mdl_a[r] = 16'h0000;
        for (int r = 0; r < 16; r++) begin
            @(negedge clk);
            ifa.rdAddr = {4'(15 - r), 4'(r)};
            exp_q.push_back(mdl_a[r]); exp_q.push_back(mdl_a[15 - r]);
            #1;
            for (int p = 0; p < 2; p++) begin
                got = ifa.rdData[p*16 +: 16]; exp = exp_q.pop_front(); checks++;
                if (got !== exp) begin errors++; $display("FAIL clear_after r%0d p%0d: got %h expected %h", r, p, got, exp); end
            end
        end
    endtask

    task automatic test_drop();
        logic [15:0] got, exp;
        logic        gbit, ebit;
        int k;
        drive_wr(0, 4'd5, 16'h0055);
        ifa.rdAddr = {4'd0, 4'd5};
        ifa.clearReq = 1'b1;
        @(negedge clk);
        k = 0;
        while (ifa.busy === 1'b1 && k < 40) begin
            k++;
            ifa.writeEn  = (k == 1);
            ifa.wrAddr   = 4'd5;
            ifa.wrData   = 16'hAAAA;
            ifa.clearReq = (k == 5);
            if (k == 1) begin exp_q.push_back(16'h0055); drop_q.push_back(1'b1); end
            if (k == 2) drop_q.push_back(1'b0);
            #1;
            if (k == 1) begin
                got = ifa.rdData[15:0]; exp = exp_q.pop_front(); checks++;
                if (got !== exp) begin errors++; $display("FAIL drop_no_bypass: got %h expected %h", got, exp); end
            end
            if (k == 2 || k == 3) begin
                gbit = ifa.wrDropped; ebit = drop_q.pop_front(); checks++;
                if (gbit !== ebit) begin errors++; $display("FAIL drop_pulse k%0d: got %b expected %b", k, gbit, ebit); end
            end
            @(negedge clk);
        end
        ifa.writeEn = 1'b0; ifa.clearReq = 1'b0;
        checks++;
        if (k !== 16) begin errors++; $display("FAIL drop_busy_len: got %0d expected 16", k); end
        for (int r = 0; r < 16; r++) mdl_a[r] = 16'h0000;
        @(negedge clk);
        exp_q.push_back(mdl_a[5]);
        #1;
        checks++;
        if (ifa.busy !== 1'b0) begin errors++; $display("FAIL drop_no_requeue: busy got %b expected 0", ifa.busy); end
        got = ifa.rdData[15:0]; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL drop_reg5: got %h expected %h", got, exp); end
    endtask

    task automatic test_restart();
        int k;
        @(negedge clk);
        ifa.clearReq = 1'b1;
        @(negedge clk);
        k = 0;
        while (ifa.busy === 1'b1 && k < 40) begin k++; @(negedge clk); end
        checks++;
        if (k !== 16) begin errors++; $display("FAIL restart_first_len: got %0d expected 16", k); end
        @(negedge clk);
        ifa.clearReq = 1'b0;
        checks++;
        if (ifa.busy !== 1'b1) begin errors++; $display("FAIL restart_second: busy got %b expected 1", ifa.busy); end
        k = 0;
        while (ifa.busy === 1'b1 && k < 40) begin k++; @(negedge clk); end
        checks++;
        if (k !== 16) begin errors++; $display("FAIL restart_second_len: got %0d expected 16", k); end
        @(negedge clk);
        checks++;
        if (ifa.busy !== 1'b0) begin errors++; $display("FAIL restart_stop: busy got %b expected 0", ifa.busy); end
    endtask

    task automatic test_zero();
        logic [15:0] got, exp;
        logic        gbit, ebit;
        @(negedge clk);
        ifb.writeEn = 1'b1; ifb.wrAddr = 4'd0; ifb.wrData = 16'hFFFF; ifb.rdAddr = 8'h00;
        ifc.writeEn = 1'b1; ifc.wrAddr = 4'd0; ifc.wrData = 16'hFFFF; ifc.rdAddr = 12'h000;
        for (int p = 0; p < 5; p++) exp_q.push_back(16'h0000);
        #1;
        for (int p = 0; p < 2; p++) begin
            got = ifb.rdData[p*16 +: 16]; exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL zero_wr_b p%0d: got %h expected %h", p, got, exp); end
        end
        for (int p = 0; p < 3; p++) begin
            got = ifc.rdData[p*16 +: 16]; exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL zero_wr_c p%0d: got %h expected %h", p, got, exp); end
        end
        @(negedge clk);
        ifb.writeEn = 1'b0; ifc.writeEn = 1'b0;
        drop_q.push_back(1'b0); drop_q.push_back(1'b0);
        exp_q.push_back(mdl_b[0]); exp_q.push_back(mdl_c[0]);
        #1;
        gbit = ifb.wrDropped; ebit = drop_q.pop_front(); checks++;
        if (gbit !== ebit) begin errors++; $display("FAIL zero_drop_b: got %b expected %b", gbit, ebit); end
        gbit = ifc.wrDropped; ebit = drop_q.pop_front(); checks++;
        if (gbit !== ebit) begin errors++; $display("FAIL zero_drop_c: got %b expected %b", gbit, ebit); end
        got = ifb.rdData[31:16]; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL zero_after_b: got %h expected %h", got, exp); end
        got = ifc.rdData[47:32]; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL zero_after_c: got %h expected %h", got, exp); end
        @(negedge clk);
        ifc.writeEn = 1'b1; ifc.wrAddr = 4'd1; ifc.wrData = 16'h0077; ifc.rdAddr = {4'd1, 4'd0, 4'd1};
        exp_q.push_back(16'h0077); exp_q.push_back(16'h0000); exp_q.push_back(16'h0077);
        #1;
        for (int p = 0; p < 3; p++) begin
            got = ifc.rdData[p*16 +: 16]; exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL c_bypass p%0d: got %h expected %h", p, got, exp); end
        end
        @(negedge clk);
        ifc.writeEn = 1'b0;
        mdl_c[1] = 16'h0077;
    endtask

    task automatic test_async_reset();
        logic [15:0] got, exp;
        drive_wr(0, 4'd2, 16'h2222);
        drive_wr(0, 4'd9, 16'h9999);
        ifa.rdAddr = {4'd9, 4'd2};
        ifa.clearReq = 1'b1;
        @(negedge clk);
        ifa.clearReq = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        resetN = 1'b0;
        #1;
        checks++;
        if ({ifa.busy, ifa.clearDone} !== 2'b00) begin
            errors++; $display("FAIL arst_ctrl: got busy=%b done=%b expected 0 0", ifa.busy, ifa.clearDone);
        end
        exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
        for (int p = 0; p < 2; p++) begin
            got = ifa.rdData[p*16 +: 16]; exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL arst_rd p%0d: got %h expected %h", p, got, exp); end
        end
        @(negedge clk);
        checks++;
        if ({ifa.busy, ifa.clearDone} !== 2'b00) begin
            errors++; $display("FAIL arst_hold: got busy=%b done=%b expected 0 0", ifa.busy, ifa.clearDone);
        end
        resetN = 1'b1;
        for (int r = 0; r < 16; r++) begin
            mdl_a[r] = 16'h0000; mdl_b[r] = 16'h0000; mdl_c[r] = 16'h0000;
        end
        for (int r = 0; r < 16; r++) begin
            @(negedge clk);
            ifa.rdAddr = {4'(15 - r), 4'(r)};
            exp_q.push_back(mdl_a[r]); exp_q.push_back(mdl_a[15 - r]);
            #1;
            for (int p = 0; p < 2; p++) begin
                got = ifa.rdData[p*16 +: 16]; exp = exp_q.pop_front(); checks++;
                if (got !== exp) begin errors++; $display("FAIL arst_array r%0d p%0d: got %h expected %h", r, p, got, exp); end
            end
        end
        drive_wr(0, 4'd2, 16'h1234);
        ifa.rdAddr = {4'd2, 4'd2};
        exp_q.push_back(16'h1234); exp_q.push_back(16'h1234);
        #1;
        for (int p = 0; p < 2; p++) begin
            got = ifa.rdData[p*16 +: 16]; exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL arst_rewrite p%0d: got %h expected %h", p, got, exp); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetN = 1'b0;
        ifa.writeEn = 1'b0; ifa.wrAddr = '0; ifa.wrData = '0; ifa.rdAddr = '0; ifa.clearReq = 1'b0;
        ifb.writeEn = 1'b0; ifb.wrAddr = '0; ifb.wrData = '0; ifb.rdAddr = '0; ifb.clearReq = 1'b0;
        ifc.writeEn = 1'b0; ifc.wrAddr = '0; ifc.wrData = '0; ifc.rdAddr = '0; ifc.clearReq = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mdl_a[i] = 16'h0000; mdl_b[i] = 16'h0000; mdl_c[i] = 16'h0000;
        end
        test_reset();
        test_basic();
        test_bypass();
        test_clear();
        test_drop();
        test_restart();
        test_zero();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
